// File: rtl/sram_col_ctrl.sv
// sram_col_ctrl: sequences precharge, wordline and write-driver/sense-amp
// control for one SRAM column. Each request runs precharge then a wordline
// access, and ends with a one-cycle response.
// Optional feature: define SRAM_COL_WRVERIFY_EN to follow every write with
// a second precharge plus a read-back of the same row. rsp_err then flags a
// bit that did not stick, or a sense that was not differential.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while idle. There is no
// response backpressure: rsp_valid is a single-cycle pulse and must be taken.
//
// Every output is a flop. The next output values are decoded from the next
// state, so each output changes on the same edge as the state it belongs to.
module sram_col_ctrl #(
  parameter int ROWS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 2,
  localparam int AW     = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_wdata,
  output logic            rsp_valid,
  output logic            rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] row_wr,
  output logic            pre_en,
  output logic            wdrv_en,
  output logic            bl_drv,
  output logic            blb_drv,
  output logic            sae,
  input  logic            sense_bl,
  input  logic            sense_blb,
  output logic [2:0]      dbg_state
);

  localparam int CMAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] WL_LAST  = CW'(WL_CYC - 1);

`ifdef SRAM_COL_WRVERIFY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ACC  = 3'd2,
    RSP  = 3'd3,
    VPRE = 3'd4,
    VACC = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ACC  = 3'd2,
    RSP  = 3'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, wdata_q;
  logic [AW-1:0]   addr_q;

  logic            accept;
  logic            addr_oor;
  logic            pre_phase_d, acc_phase_d, rd_phase_d;

  logic            req_ready_d, rsp_valid_d, rsp_rdata_d, rsp_err_d;
  logic [ROWS-1:0] row_wr_d;
  logic            pre_en_d, wdrv_en_d, bl_drv_d, blb_drv_d, sae_d;

  assign accept    = req_valid && req_ready;
  assign addr_oor  = (int'(req_addr) >= ROWS);
  assign dbg_state = state_q;

  // Next-state logic: cnt counts cycles spent in the current timed phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = addr_oor ? RSP : PRE;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACC: begin
        if (cnt_q == WL_LAST) begin
          cnt_d   = '0;
`ifdef SRAM_COL_WRVERIFY_EN
          state_d = we_q ? VPRE : RSP;
`else
          state_d = RSP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SRAM_COL_WRVERIFY_EN
      VPRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = VACC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VACC: begin
        if (cnt_q == WL_LAST) begin
          cnt_d   = '0;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase decode of the next state, shared by the output decode below.
  always_comb begin
    pre_phase_d = (state_d == PRE);
    acc_phase_d = (state_d == ACC);
    rd_phase_d  = (state_d == ACC) && !we_q;
`ifdef SRAM_COL_WRVERIFY_EN
    pre_phase_d = pre_phase_d || (state_d == VPRE);
    acc_phase_d = acc_phase_d || (state_d == VACC);
    rd_phase_d  = rd_phase_d  || (state_d == VACC);
`endif
  end

  // Next output values; the response fields are computed on the edge
  // that enters RSP, which is where the sense amp is sampled.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    pre_en_d    = pre_phase_d;
    row_wr_d    = acc_phase_d ? (ROWS'(1) << addr_q) : '0;
    wdrv_en_d   = (state_d == ACC) && we_q;
    bl_drv_d    = wdrv_en_d && wdata_q;
    blb_drv_d   = wdrv_en_d && !wdata_q;
    sae_d       = rd_phase_d && (cnt_d == WL_LAST);
    rsp_valid_d = (state_d == RSP);
    rsp_rdata_d = 1'b0;
    rsp_err_d   = 1'b0;
    if (state_d == RSP) begin
      case (state_q)
        IDLE: rsp_err_d = 1'b1;
        ACC: begin
          if (!we_q) begin
            rsp_rdata_d = sense_bl;
            rsp_err_d   = (sense_bl == sense_blb);
          end
        end
`ifdef SRAM_COL_WRVERIFY_EN
        VACC: rsp_err_d = (sense_bl != wdata_q) || (sense_bl == sense_blb);
`endif
        default: begin
          rsp_rdata_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      endcase
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured once at acceptance and held for the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Output registers; reset drops every array control line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      row_wr    <= '0;
      pre_en    <= 1'b0;
      wdrv_en   <= 1'b0;
      bl_drv    <= 1'b0;
      blb_drv   <= 1'b0;
      sae       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= req_ready_d;
      row_wr    <= row_wr_d;
      pre_en    <= pre_en_d;
      wdrv_en   <= wdrv_en_d;
      bl_drv    <= bl_drv_d;
      blb_drv   <= blb_drv_d;
      sae       <= sae_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_sram_col_ctrl.sv
// Bench for sram_col_ctrl (ROWS=6 so that out-of-range addresses exist).
// A transaction record is queued at issue time. A negedge monitor works out
// from phase arithmetic what every output must be in each cycle, and pops
// the record on the response cycle.
module tb_sram_col_ctrl;

  localparam int ROWS = 6;
  localparam int P    = 2;
  localparam int W    = 2;
  localparam int AW   = $clog2(ROWS);
  localparam int VW   = ROWS + 9;
`ifdef SRAM_COL_WRVERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic          wdata;
    logic [31:0]   base;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_we, req_wdata;
  logic [AW-1:0]   req_addr;
  logic            rsp_valid, rsp_rdata, rsp_err;
  logic [ROWS-1:0] row_wr;
  logic            pre_en, wdrv_en, bl_drv, blb_drv, sae;
  logic            sense_bl, sense_blb;
  logic [2:0]      dbg_state;

  txn_t            exp_q[$];
  logic [1:0]      sense_hist[int];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  bit              in_reset = 1'b1;
  bit              force_sense = 1'b0;
  logic [1:0]      forced_val = 2'b01;
  int              last_base = 0;

  sram_col_ctrl #(.ROWS(ROWS), .PRE_CYC(P), .WL_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .row_wr(row_wr), .pre_en(pre_en), .wdrv_en(wdrv_en),
    .bl_drv(bl_drv), .blb_drv(blb_drv), .sae(sae),
    .sense_bl(sense_bl), .sense_blb(sense_blb), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: total cycles from acceptance to the response.
  function automatic int txn_len(txn_t t);
    if (int'(t.addr) >= ROWS) return 1;
    if (t.we && VERIFY) return 2 * (P + W) + 1;
    return P + W + 1;
  endfunction

  // Reference model: expected outputs k cycles after acceptance.
  function automatic logic [VW-1:0] expect_vec(txn_t t, int k, logic sbl, logic sblb);
    logic [ROWS-1:0] row;
    logic pre, wdrv, bl, blb, sa, rv, rd, re;
    row = '0; pre = 0; wdrv = 0; bl = 0; blb = 0; sa = 0; rv = 0; rd = 0; re = 0;
    if (k == txn_len(t)) begin
      rv = 1'b1;
      if (int'(t.addr) >= ROWS) re = 1'b1;
      else if (!t.we) begin
        rd = sbl;
        re = (sbl == sblb);
      end else if (VERIFY) re = (sbl != t.wdata) || (sbl == sblb);
    end else if (k <= P) begin
      pre = 1'b1;
    end else if (k <= P + W) begin
      row[int'(t.addr)] = 1'b1;
      if (t.we) begin
        wdrv = 1'b1;
        bl   = t.wdata;
        blb  = ~t.wdata;
      end else sa = (k == P + W);
    end else if (k <= 2 * P + W) begin
      pre = 1'b1;
    end else begin
      row[int'(t.addr)] = 1'b1;
      sa = (k == 2 * (P + W));
    end
    return {1'b0, row, pre, wdrv, bl, blb, sa, rv, rd, re};
  endfunction

  // Sense-line driver: random levels unless a directed test forces them.
  initial begin
    sense_bl = 1'b0;
    sense_blb = 1'b1;
    forever begin
      @(negedge clk);
      if (force_sense) {sense_bl, sense_blb} = forced_val;
      else {sense_bl, sense_blb} = 2'($urandom_range(0, 3));
      sense_hist[cyc] = {sense_bl, sense_blb};
    end
  end

  // Monitor / scoreboard: compares all outputs every cycle.
  always @(negedge clk) begin
    logic [VW-1:0] act, exp_v;
    logic [1:0]    s;
    int            k;
    bit            active;
    act = {req_ready, row_wr, pre_en, wdrv_en, bl_drv, blb_drv, sae,
           rsp_valid, rsp_rdata, rsp_err};
    if (in_reset) begin
      if (!rst_n) begin
        checks++;
        if (act !== '0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, act, {VW{1'b0}});
        end
      end
    end else begin
      exp_v  = {1'b1, {(VW-1){1'b0}}};
      active = 1'b0;
      k      = 0;
      if (exp_q.size() > 0) begin
        k = cyc - int'(exp_q[0].base);
        if (k >= 1) begin
          active = 1'b1;
          s = sense_hist.exists(cyc - 1) ? sense_hist[cyc - 1] : 2'b00;
          exp_v = expect_vec(exp_q[0], k, s[1], s[0]);
        end
      end
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s cyc=%0d k=%0d got=%h want=%h",
                 active ? "txn_outputs" : "idle_outputs", cyc, k, act, exp_v);
      end
      if (active && k >= txn_len(exp_q[0])) void'(exp_q.pop_front());
    end
  end

  // Driver: wait for ready (junk on req_* while busy), then issue one request.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic wd);
    txn_t t;
    int   tries = 0;
    @(negedge clk);
    while (!req_ready && tries < 50) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 7));
      req_wdata = 1'($urandom_range(0, 1));
      @(negedge clk);
      tries++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout cyc=%0d got=0 want=1", cyc);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    t.we = we; t.addr = addr; t.wdata = wd; t.base = 32'(cyc);
    last_base = cyc;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom_range(0, 7));
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      req_valid = 1'b0;
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  // Reset asserted in the middle of a write's wordline phase.
  task automatic reset_mid_acc();
    int t = 0;
    issue(1'b1, 3'd3, 1'b1);
    while (cyc != last_base + P + 1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    in_reset  = 1'b1;
    exp_q.delete();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (row_wr !== '0 || wdrv_en !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got row_wr=%h wdrv_en=%b rsp_valid=%b want 0 0 0",
               row_wr, wdrv_en, rsp_valid);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 in_reset = 1'b0;
  endtask

  // Stimulus sequence: directed cases, then randomized traffic.
  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 in_reset = 1'b0;

    issue(1'b1, 3'd3, 1'b1);
    drain();
    force_sense = 1'b1; forced_val = 2'b01;
    issue(1'b0, 3'd5, 1'b0);
    drain();
    forced_val = 2'b11;
    issue(1'b0, 3'd2, 1'b0);
    drain();
    forced_val = 2'b10;
    issue(1'b0, 3'd0, 1'b0);
    drain();
    forced_val = 2'b01;
    issue(1'b1, 3'd4, 1'b1);
    drain();
    forced_val = 2'b10;
    issue(1'b1, 3'd1, 1'b1);
    drain();
    force_sense = 1'b0;
    issue(1'b0, 3'd7, 1'b0);
    issue(1'b1, 3'd6, 1'b1);
    issue(1'b0, 3'd5, 1'b0);
    drain();

    reset_mid_acc();
    issue(1'b1, 3'd2, 1'b0);
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end
    drain();
    gap(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_col_ctrl.md
SRAM_COL_CTRL -- requirements
Module: sram_col_ctrl

Interface
REQ-001 Parameter: ROWS, 8, number of cells (wordlines) on the column; SHALL be >= 2.
REQ-002 Parameter: PRE_CYC, 2, bitline precharge duration in clock cycles; SHALL be >= 1.
REQ-003 Parameter: WL_CYC, 2, wordline-on duration in clock cycles; SHALL be >= 1.
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  in  1  access request present.
REQ-007 Port: req_ready  out  1  controller can accept a request.
REQ-008 Port: req_we  in  1  1 = write, 0 = read.
REQ-009 Port: req_addr  in  AW = $clog2(ROWS)  target row.
REQ-010 Port: req_wdata  in  1  write bit.
REQ-011 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 Port: rsp_rdata  out  1  read bit, valid with rsp_valid.
REQ-013 Port: rsp_err  out  1  error flag, valid with rsp_valid.
REQ-014 Port: row_wr  out  ROWS  one-hot wordline vector to the cells.
REQ-015 Port: pre_en  out  1  bitline precharge enable.
REQ-016 Port: wdrv_en  out  1  write-driver enable.
REQ-017 Port: bl_drv, blb_drv  out  1 each  differential write data to the bitlines.
REQ-018 Port: sae  out  1  sense-amp enable.
REQ-019 Port: sense_bl, sense_blb  in  1 each  sensed bitline levels.

Function
REQ-020 FSM states: IDLE, PRE, ACC, RSP (and VPRE, VACC under REQ-033). All outputs SHALL be registered.
REQ-021 req_ready SHALL be 1 only in IDLE. A request is accepted on an edge with req_valid && req_ready. req_we, req_addr and req_wdata SHALL be latched at acceptance.
REQ-022 Accepted in-range request: PRE for PRE_CYC cycles, then ACC for WL_CYC cycles, then RSP for 1 cycle, then IDLE.
REQ-023 rsp_valid SHALL be 1 only in RSP. With acceptance at edge T, rsp_valid SHALL be high in cycle T+PRE_CYC+WL_CYC+1.
REQ-024 PRE: pre_en=1; row_wr=0; wdrv_en=0; sae=0.
REQ-025 ACC: row_wr has exactly bit[addr] set; pre_en=0.
- Write: wdrv_en=1, bl_drv=wdata, blb_drv=~wdata.
- Read: wdrv_en=0; sae=1 on the last ACC cycle only.
REQ-026 Read: rsp_rdata SHALL capture sense_bl on the edge that ends the last ACC cycle. rsp_err=1 if sense_bl==sense_blb at that edge (non-differential), else 0.
REQ-027 pre_en and any row_wr bit SHALL never be high in the same cycle. row_wr SHALL never have more than one bit set.
REQ-028 Out-of-range address (addr >= ROWS): no PRE or ACC; row_wr stays 0. RSP SHALL occur in cycle T+1 with rsp_err=1 and rsp_rdata=0.
REQ-029 Write without REQ-033: rsp_err=0, rsp_rdata=0.
REQ-030 There is no response backpressure. req_valid asserted outside IDLE SHALL be ignored. A new request MAY be accepted in the first IDLE cycle after RSP.

Reset
REQ-031 rst_n low SHALL asynchronously force:
- state IDLE;
- row_wr, pre_en, wdrv_en, bl_drv, blb_drv, sae, rsp_valid, rsp_rdata, rsp_err all 0;
- req_ready 0 while rst_n is low, then 1 on the first edge after release.
REQ-032 Reset mid-operation SHALL abort the access with no response issued.

Configuration
REQ-033 Macro SRAM_COL_WRVERIFY_EN.
- Defined: after a write's ACC, the FSM SHALL run VPRE (PRE_CYC cycles, as PRE) and then VACC (WL_CYC cycles, as a read ACC on the same row). rsp_err=1 if the sensed bit differs from wdata or the sense is non-differential. Write latency becomes 2*(PRE_CYC+WL_CYC)+1.
- Undefined: VPRE and VACC SHALL not exist, and write latency equals read latency.

Verification
REQ-034 ROWS=8, PRE_CYC=2, WL_CYC=2. Write addr=3, wdata=1 -> pre_en high cycles 1-2; row_wr=8'h08, wdrv_en=1, bl_drv=1, blb_drv=0 in cycles 3-4; rsp_valid=1, rsp_err=0 in cycle 5.
REQ-035 Read addr=5 with sense_bl=0, sense_blb=1 -> row_wr=8'h20 in cycles 3-4; sae=1 in cycle 4 only; cycle 5 rsp_valid=1, rsp_rdata=0, rsp_err=0.
REQ-036 Read with sense_bl=sense_blb=1 -> rsp_err=1 in cycle 5.
REQ-037 ROWS=6, request addr=7 -> cycle 1 rsp_valid=1, rsp_err=1; row_wr and pre_en stay 0 throughout.
REQ-038 rst_n pulled low during ACC -> row_wr=0 and wdrv_en=0 immediately, no rsp_valid; after release, req_ready=1 and the next write completes normally.
REQ-039 With SRAM_COL_WRVERIFY_EN, write wdata=1 and sense_bl=0, sense_blb=1 during VACC -> rsp_valid=1, rsp_err=1 in cycle 9. With matching sense -> rsp_err=0 in cycle 9.
